// File: rtl/integral_image_gen.sv
// integral_image_gen: streams a raster frame in and emits ii(x,y) per pixel, using a running row sum plus a one-row line buffer.
module integral_image_gen #(
  parameter int IMG_W = 24,
  parameter int IMG_H = 24,
  parameter int PIX_W = 8,
  parameter int II_W  = 20
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      pix_valid,
  input  logic [PIX_W-1:0]          pix_data,
  output logic                      pix_ready,
  output logic                      ii_valid,
  output logic [II_W-1:0]           ii_data,
  output logic [$clog2(IMG_W)-1:0]  ii_x,
  output logic [$clog2(IMG_H)-1:0]  ii_y,
  input  logic                      ii_ready,
  output logic                      frame_done
);
  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2;
  logic [1:0] state;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [II_W-1:0] row_sum, row_next, ii_next;
  logic [II_W-1:0] line_buf [IMG_W];
  logic acc, last_x, last_y;
  assign pix_ready  = state == RUN && (!ii_valid || ii_ready);
  assign acc        = pix_valid && pix_ready;
  assign frame_done = state == DRAIN && ii_valid && ii_ready;
  assign last_x     = x == XW'(IMG_W - 1);
  assign last_y     = y == YW'(IMG_H - 1);
  // row 0 has no row above, so stale line-buffer contents never leak in
  assign row_next   = (x == '0 ? '0 : row_sum) + II_W'(pix_data);
  assign ii_next    = row_next + (y == '0 ? '0 : line_buf[x]);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= IDLE;
      x        <= '0;
      y        <= '0;
      row_sum  <= '0;
      ii_valid <= 1'b0;
      ii_data  <= '0;
      ii_x     <= '0;
      ii_y     <= '0;
    end else begin
      if (state == IDLE && start) begin
        state   <= RUN;
        x       <= '0;
        y       <= '0;
        row_sum <= '0;
      end
      if (acc) begin
        row_sum  <= row_next;
        x        <= last_x ? '0 : x + 1'b1;
        if (last_x) y <= last_y ? '0 : y + 1'b1;
        if (last_x && last_y) state <= DRAIN;
        ii_valid <= 1'b1;
        ii_data  <= ii_next;
        ii_x     <= x;
        ii_y     <= y;
      end else if (ii_ready) ii_valid <= 1'b0;
      if (frame_done) state <= IDLE;
    end
  always_ff @(posedge clk)
    if (acc) line_buf[x] <= ii_next;
endmodule
